// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked front end for a NOR SR latch.
// Two raw buttons are synchronised and debounced into rising-edge requests,
// which become mutually exclusive, fixed-width s/r pulses. After each pulse
// the synchronised latch outputs are checked against the expected state.
module sr_latch_driver #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_LEN  = 3,
    parameter int CHK_WAIT   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_rst,
    input  logic q,
    input  logic qb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic drop,
    output logic err
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (PULSE_LEN > CHK_WAIT) ? PULSE_LEN : CHK_WAIT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, CHECK} state_t;

    // Bit order: 0 = set button, 1 = reset button, 2 = q, 3 = qb
    logic [3:0] raw_in;
    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic [1:0] req;

    assign raw_in = {qb, q, btn_rst, btn_set};

    // Two-flop synchronisers for every asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_in;
            sync_q <= meta_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic          deb_q;
            logic          deb_prev_q;
            logic [DW-1:0] cnt_q;

            // Level changes only after DEB_CYCLES consecutive disagreeing samples
            always_ff @(posedge clk) begin
                if (rst) begin
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    cnt_q      <= '0;
                end else begin
                    deb_prev_q <= deb_q;
                    if (sync_q[gi] == deb_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                        deb_q <= sync_q[gi];
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + DW'(1);
                    end
                end
            end

            // A request is the single cycle after the debounced level rises
            assign req[gi] = deb_q & ~deb_prev_q;
        end
    endgenerate

    state_t        state_q;
    logic [TW-1:0] tcnt_q;
    logic          exp_set_q;
    logic          s_q, r_q, done_q, drop_q, err_q;
    logic          drop_pend_q;
    logic          drop_d;
    logic          drop_pend_d;
    logic          check_ok;

    // Discards: while busy every request is dropped; in IDLE only the losing
    // set request of a simultaneous pair. A second simultaneous discard is
    // deferred one cycle so each discarded request gets its own pulse.
    always_comb begin
        drop_d      = drop_pend_q;
        drop_pend_d = 1'b0;
        if (state_q != IDLE) begin
            drop_d      = drop_pend_q | req[0] | req[1];
            drop_pend_d = req[0] & req[1];
        end else if (req[0] && req[1]) begin
            drop_d = 1'b1;
        end
    end

    assign check_ok = exp_set_q ? (sync_q[2] & ~sync_q[3]) : (~sync_q[2] & sync_q[3]);

    // Control FSM: pulse generation, post-pulse check, registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            exp_set_q   <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            drop_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            drop_q      <= drop_d;
            drop_pend_q <= drop_pend_d;
            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (req[1]) begin
                        state_q   <= PULSE_R;
                        r_q       <= 1'b1;
                        exp_set_q <= 1'b0;
                    end else if (req[0]) begin
                        state_q   <= PULSE_S;
                        s_q       <= 1'b1;
                        exp_set_q <= 1'b1;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (tcnt_q == TW'(PULSE_LEN - 1)) begin
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        tcnt_q  <= '0;
                        state_q <= CHECK;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                CHECK: begin
                    if (tcnt_q == TW'(CHK_WAIT - 1)) begin
                        done_q  <= 1'b1;
                        tcnt_q  <= '0;
                        state_q <= IDLE;
                        if (!check_ok) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign drop = drop_q;
    assign err  = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Testbench for sr_latch_driver: directed and random button transactions,
// with a behavioural latch model and per-transaction expected outcomes.
module tb_sr_latch_driver;

    localparam int DEB = 4;
    localparam int PL  = 3;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_set = 1'b0;
    logic btn_rst = 1'b0;
    logic q = 1'b0;
    logic qb = 1'b1;
    logic s, r, busy, done, drop, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor state, cleared at the start of every transaction
    int s_hi, r_hi, both_hi, done_n, drop_n, first_rise;
    int latch_mode = 0;
    logic lq = 1'b0;
    logic err_exp = 1'b0;
    int txn_id = 0;

    sr_latch_driver #(.DEB_CYCLES(DEB), .PULSE_LEN(PL), .CHK_WAIT(CW)) dut (
        .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
        .q(q), .qb(qb), .s(s), .r(r), .busy(busy), .done(done),
        .drop(drop), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, got, exp, txn_id);
        end
    endtask

    // Latch model and output monitor, on the inactive edge
    always @(negedge clk) begin
        if (s) s_hi++;
        if (r) r_hi++;
        if (s && r) both_hi++;
        if (done) done_n++;
        if (drop) drop_n++;
        if ((s || r) && first_rise < 0) first_rise = cyc;
        if (s && !r) lq = 1'b1;
        else if (r && !s) lq = 1'b0;
        case (latch_mode)
            0: begin q = lq;   qb = ~lq; end
            1: begin q = 1'b0; qb = 1'b0; end
            2: begin q = 1'b1; qb = 1'b1; end
            default: begin q = ~lq; qb = lq; end
        endcase
    end

    task automatic drive_btn(input int b, input logic v);
        if (b == 0) btn_set = v;
        else btn_rst = v;
    endtask

    // kind: 0 set press, 1 reset press, 2 both together, 3 glitch,
    //       4 press then other press while busy, 5 rst in 2nd pulse cycle
    task automatic run_txn(input int kind, input int mode);
        int n_edge, hold, b, off, exp_s, exp_r, exp_done, exp_drop;
        bit chk_lat, found;
        txn_id++;
        latch_mode = mode;
        @(posedge clk); #1;
        s_hi = 0; r_hi = 0; both_hi = 0; done_n = 0; drop_n = 0; first_rise = -1;
        n_edge = cyc + 1;
        exp_s = 0; exp_r = 0; exp_done = 0; exp_drop = 0; chk_lat = 0;
        b = $urandom_range(0, 1);
        case (kind)
            0, 1: begin
                b = kind;
                hold = $urandom_range(DEB + 1, 20);
                drive_btn(b, 1'b1);
                repeat (hold) @(posedge clk);
                #1 drive_btn(b, 1'b0);
                if (b == 0) exp_s = PL; else exp_r = PL;
                exp_done = 1; chk_lat = 1;
                if (mode != 0) err_exp = 1'b1;
            end
            2: begin
                hold = $urandom_range(DEB + 1, 20);
                btn_set = 1'b1; btn_rst = 1'b1;
                repeat (hold) @(posedge clk);
                #1 btn_set = 1'b0; btn_rst = 1'b0;
                exp_r = PL; exp_done = 1; exp_drop = 1; chk_lat = 1;
                if (mode != 0) err_exp = 1'b1;
            end
            3: begin
                hold = $urandom_range(1, DEB - 1);
                drive_btn(b, 1'b1);
                repeat (hold) @(posedge clk);
                #1 drive_btn(b, 1'b0);
            end
            4: begin
                off = $urandom_range(1, 5);
                drive_btn(b, 1'b1);
                repeat (off) @(posedge clk);
                #1 drive_btn(1 - b, 1'b1);
                repeat (15 - off) @(posedge clk);
                #1 btn_set = 1'b0; btn_rst = 1'b0;
                if (b == 0) exp_s = PL; else exp_r = PL;
                exp_done = 1; exp_drop = 1; chk_lat = 1;
                if (mode != 0) err_exp = 1'b1;
            end
            default: begin
                drive_btn(b, 1'b1);
                repeat (DEB + 1) @(posedge clk);
                #1 drive_btn(b, 1'b0);
                found = 0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    if (s || r) found = 1;
                end
                check_val("pulse_seen", found, 1);
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                check_val("rst_s", s, 0);
                check_val("rst_r", r, 0);
                check_val("rst_busy", busy, 0);
                if (b == 0) exp_s = 2; else exp_r = 2;
                err_exp = 1'b0;
            end
        endcase
        while (cyc < n_edge + 44) @(posedge clk);
        #1;
        check_val("s_cycles", s_hi, exp_s);
        check_val("r_cycles", r_hi, exp_r);
        check_val("s_r_overlap", both_hi, 0);
        check_val("done_count", done_n, exp_done);
        check_val("drop_count", drop_n, exp_drop);
        check_val("err", err, err_exp);
        check_val("busy_idle", busy, 0);
        if (chk_lat) check_val("latency", first_rise - n_edge, 2 + DEB);
        else if (kind == 3) check_val("no_pulse", first_rise, -1);
        $display("txn %0d kind %0d mode %0d: s_hi=%0d r_hi=%0d done=%0d drop=%0d err=%0b",
                 txn_id, kind, mode, s_hi, r_hi, done_n, drop_n, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_s", s, 0);
        check_val("reset_r", r, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_drop", drop, 0);
        check_val("reset_err", err, 0);
        @(posedge clk); #1 rst = 1'b0;
        // Directed sequence first, then random transactions
        run_txn(0, 0);
        run_txn(1, 0);
        run_txn(3, 0);
        run_txn(2, 0);
        run_txn(4, 0);
        run_txn(0, 1);
        run_txn(1, 0);
        run_txn(5, 0);
        for (int k = 0; k < 24; k++) begin
            run_txn($urandom_range(0, 5), $urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
